boot_ctrl: RTL and testbench
============================

# boot_ctrl

Boot and run sequencer for the single-cycle core. It holds the core in reset and streams a program from a byte-wide loader channel into instruction memory as little-endian 32-bit words starting at byte address 0. It then releases the core at PC 0, supports debug pause through the core's `test_halt`, and reports completion when the core halts or a cycle watchdog expires. It sits between the testbench/host loader and the `cpu` top.

## Interface

Parameters:
- `MAX_CYCLES`, default 100000: watchdog limit on run cycles; 0 disables the watchdog.
- `LEN_W`, default 16: width of the program-length field, in words.

Ports:
- `clk`  in  1: single clock.
- `reset`  in  1: synchronous, active-high.
- `start`  in  1: single-cycle request to load and run; honoured only in IDLE, DONE and TIMEOUT.
- `load_len`  in  LEN_W: number of instruction words to load; sampled when `start` is accepted.
- `rx_valid`  in  1: loader byte valid.
- `rx_data`  in  8: loader byte.
- `rx_ready`  out  1: controller accepts a byte.
- `imem_we`  out  1: instruction-memory write strobe.
- `imem_addr`  out  64: byte address of the write, equal to word index × 4.
- `imem_wdata`  out  32: assembled instruction word.
- `cpu_reset`  out  1: drives the core's `reset`.
- `cpu_test_halt`  out  1: drives the core's `test_halt`.
- `cpu_halted`  in  1: the core's `halted`.
- `pause_req`  in  1: level request to freeze the core.
- `busy`  out  1: high in LOAD, RELEASE, RUN and PAUSE.
- `done`  out  1: the core halted normally.
- `timeout`  out  1: the watchdog expired.
- `run_cycles`  out  32: cycles spent in RUN.

## Operation

- States: IDLE, LOAD, WRITE, RELEASE, RUN, PAUSE, DONE, TIMEOUT.
- Reset values:
  - State is IDLE.
  - `cpu_reset` is 1.
  - All other outputs are 0: `cpu_test_halt`, `rx_ready`, `imem_we`, `imem_addr`, `imem_wdata`, `busy`, `done`, `timeout`, `run_cycles`.
  - The internal byte and word counters are 0.
- Asserting `reset` in any state, including mid-load or mid-run, returns the block to the reset values on the next edge. Partially assembled words are discarded.
- IDLE:
  - `cpu_reset` is 1.
  - On `start`, latch `load_len` and clear the counters.
  - Go to LOAD, or to RELEASE if `load_len` is 0.
- LOAD:
  - `rx_ready` is 1.
  - Each accepted byte (`rx_valid & rx_ready`) is stored at bits [8k+7:8k] of the word, where k is the byte count (0 to 3).
  - When the 4th byte is accepted, go to WRITE.
- WRITE:
  - `imem_we` is 1 for exactly one cycle, with `imem_addr` = word_cnt × 4 and `imem_wdata` = the assembled word.
  - `rx_ready` is 0.
  - word_cnt increments. If the new count equals the latched length, go to RELEASE; otherwise return to LOAD.
- RELEASE:
  - Lasts one cycle with `cpu_reset` still 1, so the core's PC is 0.
  - Clear `run_cycles`, then go to RUN.
- RUN:
  - `cpu_reset` and `cpu_test_halt` are 0.
  - `run_cycles` increments each cycle.
  - Exit priority: `cpu_halted` goes to DONE; else the watchdog (`MAX_CYCLES` ≠ 0 and `run_cycles` = `MAX_CYCLES` − 1) goes to TIMEOUT; else `pause_req` goes to PAUSE.
- PAUSE:
  - `cpu_test_halt` is 1 and `run_cycles` is frozen.
  - `cpu_halted` goes to DONE; `pause_req` = 0 goes to RUN.
- DONE:
  - `done` is 1 and `cpu_reset` stays 0, so the core's architectural state stays visible.
  - `cpu_test_halt` is 0.
- TIMEOUT: `timeout` is 1 and `cpu_test_halt` is 1.
- Restart from DONE or TIMEOUT: `start` clears `done`, `timeout` and `run_cycles`, sets `cpu_reset` to 1, latches `load_len`, and proceeds as from IDLE.
- `start` in LOAD, WRITE, RELEASE, RUN or PAUSE is ignored.
- `rx_valid` outside LOAD is ignored.
- With `MAX_CYCLES` = 0, `run_cycles` saturates at 0xFFFFFFFF.
- `imem_addr` is zero-extended from word_cnt × 4.
- A length of 2^LEN_W − 1 words loads completely without counter wrap.

## Timing

- All outputs are registered and change only on `clk` rising edges.
- Byte acceptance uses a valid/ready handshake. The loader may hold `rx_valid` high continuously, giving one byte per cycle.
- Per word, the block takes 4 accept cycles plus 1 WRITE cycle, so N words take 5N cycles from LOAD entry to RELEASE.
- Start to first core cycle:
  - `start` in cycle t puts LOAD in t+1.
  - With load_len = 0: RELEASE in t+1 and `cpu_reset` falls at t+2.
- `pause_req` rising in cycle t gives `cpu_test_halt` = 1 in t+1. Falling in PAUSE at cycle t gives `cpu_test_halt` = 0 in t+1.
- `cpu_halted` high in cycle t gives `done` = 1 and `busy` = 0 in t+1.
- `run_cycles` equals the number of RUN-state cycles; PAUSE cycles are excluded.

## Test plan

- **Two-word load:** reset, then `start` with load_len = 2 and bytes 0x11, 0x22, 0x33, 0x44, 0x55, 0x66, 0x77, 0x88 streamed back-to-back.
  - Two `imem_we` pulses: (addr 0, 0x44332211) then (addr 4, 0x88776655).
  - `rx_ready` is low in each WRITE cycle.
  - `cpu_reset` falls 11 cycles after `start`.
- **Gapped loader:** same stream with `rx_valid` toggling every other cycle.
  - Identical writes, no lost or duplicated bytes, and `rx_ready` is never high outside LOAD.
- **Pause then halt:** run a 3-word program, assert `pause_req` for 5 cycles mid-run, then `cpu_halted` rises.
  - `cpu_test_halt` is high for exactly those 5 cycles, each delayed by one cycle.
  - `run_cycles` excludes the pause.
  - `done` = 1 and a later `start` is accepted.
- **Watchdog:** `MAX_CYCLES` = 20 and `cpu_halted` is never asserted.
  - `timeout` = 1 and `cpu_test_halt` = 1 after 20 RUN cycles.
  - `run_cycles` = 20 and `done` = 0.
- **Simultaneous events:** `cpu_halted` and `pause_req` asserted together, and separately `cpu_halted` on the watchdog cycle.
  - DONE in both cases and `timeout` stays 0.
- **Reset mid-load:** `reset` after 2 bytes of word 1, then a full reload.
  - All reset values hold.
  - The first write after reload is at addr 0 containing only new bytes.

Source files
------------

// File: rtl/boot_ctrl.sv
// boot_ctrl: boot and run sequencer for the single-cycle core.
//   Loads a program from a byte-wide valid/ready loader channel into
//   instruction memory as little-endian 32-bit words from byte address 0.
//   It then releases the core at PC 0, freezes it through test_halt on
//   pause_req, and reports completion on core halt or on a watchdog.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   start, load_len     load-and-run request, program length in words
//   rx_valid/rx_data    loader byte stream; rx_ready accepts a byte
//   imem_we/addr/wdata  instruction-memory write port (byte address)
//   cpu_reset           core reset, cpu_test_halt freezes the core, cpu_halted from core
//   pause_req           level request to freeze the running core
//   busy, done, timeout status; run_cycles counts RUN-state cycles
module boot_ctrl #(
    parameter int MAX_CYCLES = 100000,
    parameter int LEN_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] load_len,
    input  logic             rx_valid,
    input  logic [7:0]       rx_data,
    output logic             rx_ready,
    output logic             imem_we,
    output logic [63:0]      imem_addr,
    output logic [31:0]      imem_wdata,
    output logic             cpu_reset,
    output logic             cpu_test_halt,
    input  logic             cpu_halted,
    input  logic             pause_req,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [31:0]      run_cycles
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_WRITE, S_RELEASE, S_RUN, S_PAUSE, S_DONE, S_TIMEOUT
    } state_t;

    localparam bit          WD_EN   = (MAX_CYCLES != 0);
    localparam logic [31:0] WD_LAST = WD_EN ? 32'(MAX_CYCLES - 1) : 32'd0;
    localparam logic [LEN_W:0] W_ONE = 1;

    state_t           state, state_nx;
    logic [LEN_W-1:0] len_q;
    // One bit wider than the length so a full 2^LEN_W-1 load never wraps.
    logic [LEN_W:0]   word_cnt;
    logic [LEN_W:0]   word_inc;
    logic [1:0]       byte_cnt;
    logic [31:0]      word_q, word_nx;
    logic             accept, start_ok, wd_hit;

    assign accept   = (state == S_LOAD) && rx_valid;
    assign start_ok = start && (state == S_IDLE || state == S_DONE || state == S_TIMEOUT);
    assign wd_hit   = WD_EN && (run_cycles == WD_LAST);
    assign word_inc = word_cnt + W_ONE;

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        word_nx  = word_q;
        if (accept) word_nx[{byte_cnt, 3'b000} +: 8] = rx_data;
        case (state)
            S_IDLE, S_DONE, S_TIMEOUT:
                if (start) state_nx = (load_len == '0) ? S_RELEASE : S_LOAD;
            S_LOAD:
                if (accept && byte_cnt == 2'd3) state_nx = S_WRITE;
            S_WRITE:
                state_nx = (word_inc == {1'b0, len_q}) ? S_RELEASE : S_LOAD;
            S_RELEASE:
                state_nx = S_RUN;
            S_RUN:
                if (cpu_halted)     state_nx = S_DONE;
                else if (wd_hit)    state_nx = S_TIMEOUT;
                else if (pause_req) state_nx = S_PAUSE;
            S_PAUSE:
                if (cpu_halted)      state_nx = S_DONE;
                else if (!pause_req) state_nx = S_RUN;
            default:
                state_nx = S_IDLE;
        endcase
    end

    // Datapath and outputs. Status outputs are registered decodes of the
    // next state, so they line up with the state register cycle for cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            len_q         <= '0;
            word_cnt      <= '0;
            byte_cnt      <= '0;
            word_q        <= '0;
            rx_ready      <= 1'b0;
            imem_we       <= 1'b0;
            imem_addr     <= '0;
            imem_wdata    <= '0;
            cpu_reset     <= 1'b1;
            cpu_test_halt <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            timeout       <= 1'b0;
            run_cycles    <= '0;
        end else begin
            if (start_ok) begin
                len_q    <= load_len;
                word_cnt <= '0;
                byte_cnt <= '0;
                word_q   <= '0;
            end
            if (accept) begin
                word_q   <= word_nx;
                byte_cnt <= byte_cnt + 2'd1;   // wraps to 0 after the 4th byte
            end
            if (state == S_WRITE) word_cnt <= word_inc;

            // Address and data are captured together with the strobe; the
            // 4th byte comes straight from word_nx.
            imem_we    <= (state_nx == S_WRITE);
            imem_addr  <= (state_nx == S_WRITE) ? 64'({word_cnt, 2'b00}) : 64'd0;
            imem_wdata <= (state_nx == S_WRITE) ? word_nx : 32'd0;

            if (start_ok || state == S_RELEASE)
                run_cycles <= '0;
            else if (state == S_RUN && run_cycles != 32'hFFFF_FFFF)
                run_cycles <= run_cycles + 32'd1;

            rx_ready      <= (state_nx == S_LOAD);
            cpu_reset     <= (state_nx == S_IDLE) || (state_nx == S_LOAD) ||
                             (state_nx == S_WRITE) || (state_nx == S_RELEASE);
            cpu_test_halt <= (state_nx == S_PAUSE) || (state_nx == S_TIMEOUT);
            // busy covers LOAD, RELEASE, RUN and PAUSE; the WRITE cycle is excluded.
            busy          <= (state_nx == S_LOAD) || (state_nx == S_RELEASE) ||
                             (state_nx == S_RUN) || (state_nx == S_PAUSE);
            done          <= (state_nx == S_DONE);
            timeout       <= (state_nx == S_TIMEOUT);
        end
    end

endmodule

// File: tb/tb_boot_ctrl.sv
// Testbench for boot_ctrl: scoreboard of expected imem writes plus
// directed checks of the run/pause/halt/watchdog sequencing.
module tb_boot_ctrl;
    localparam int LEN_W = 16;
    localparam int MAXC  = 20;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [LEN_W-1:0] load_len = '0;
    logic             rx_valid = 1'b0;
    logic [7:0]       rx_data = '0;
    logic             cpu_halted = 1'b0;
    logic             pause_req = 1'b0;
    logic             rx_ready, imem_we, cpu_reset, cpu_test_halt, busy, done, timeout;
    logic [63:0]      imem_addr;
    logic [31:0]      imem_wdata, run_cycles;

    boot_ctrl #(.MAX_CYCLES(MAXC), .LEN_W(LEN_W)) dut (
        .clk(clk), .reset(reset), .start(start), .load_len(load_len),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_reset(cpu_reset), .cpu_test_halt(cpu_test_halt), .cpu_halted(cpu_halted),
        .pause_req(pause_req), .busy(busy), .done(done), .timeout(timeout),
        .run_cycles(run_cycles)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;
    int start_cyc = 0;

    typedef struct {
        logic [63:0] addr;
        logic [31:0] data;
    } wr_t;
    wr_t exp_q[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Write monitor: every strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!reset) begin
            if (imem_we) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", 64'(imem_addr), 64'hFFFF_FFFF);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    chk("wr_addr", imem_addr, e.addr);
                    chk("wr_data", 64'(imem_wdata), 64'(e.data));
                end
                chk("rdy_in_write", 64'(rx_ready), 64'(0));
            end
            if (rx_ready && (!cpu_reset || done || timeout || !busy))
                chk("rdy_outside_load", 64'(rx_ready), 64'(0));
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // start is sampled by the next edge; start_cyc marks that edge.
    task automatic do_start(input int n);
        start = 1'b1;
        load_len = LEN_W'(n);
        tick();
        start_cyc = cyc;
        start = 1'b0;
    endtask

    task automatic push_prog(input logic [7:0] b[$]);
        for (int w = 0; w < b.size() / 4; w++) begin
            wr_t e;
            e.addr = 64'(w * 4);
            e.data = {b[4*w+3], b[4*w+2], b[4*w+1], b[4*w]};
            exp_q.push_back(e);
        end
    endtask

    task automatic stream(input logic [7:0] b[$], input bit gapped);
        foreach (b[i]) begin
            int g;
            if (gapped) begin
                rx_valid = 1'b0;
                tick();
            end
            rx_valid = 1'b1;
            rx_data  = b[i];
            g = 0;
            while (!rx_ready && g < 50) begin
                tick();
                g++;
            end
            if (!rx_ready) chk("rx_ready_wait", 64'(rx_ready), 64'(1));
            tick();
        end
        rx_valid = 1'b0;
    endtask

    // Returns in the first RUN cycle (cpu_reset low).
    task automatic wait_run();
        int g;
        g = 0;
        while (cpu_reset && g < 200) begin
            tick();
            g++;
        end
        chk("run_entry", 64'(cpu_reset), 64'(0));
    endtask

    // Called in RUN cycle 1; raises cpu_halted during RUN cycle k.
    task automatic run_then_halt(input int k);
        for (int i = 1; i < k; i++) tick();
        cpu_halted = 1'b1;
        tick();
        cpu_halted = 1'b0;
        chk("halt_done", 64'(done), 64'(1));
        chk("halt_busy", 64'(busy), 64'(0));
        chk("halt_runcyc", 64'(run_cycles), 64'(k));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_cpu_reset"}, 64'(cpu_reset), 64'(1));
        chk({tag, "_rx_ready"}, 64'(rx_ready), 64'(0));
        chk({tag, "_imem_we"}, 64'(imem_we), 64'(0));
        chk({tag, "_imem_addr"}, imem_addr, 64'(0));
        chk({tag, "_imem_wdata"}, 64'(imem_wdata), 64'(0));
        chk({tag, "_test_halt"}, 64'(cpu_test_halt), 64'(0));
        chk({tag, "_busy"}, 64'(busy), 64'(0));
        chk({tag, "_done"}, 64'(done), 64'(0));
        chk({tag, "_timeout"}, 64'(timeout), 64'(0));
        chk({tag, "_run_cycles"}, 64'(run_cycles), 64'(0));
    endtask

    initial begin
        logic [7:0] b[$];

        // Reset values
        repeat (3) tick();
        chk_reset_vals("rst");
        reset = 1'b0;
        tick();

        // Two-word back-to-back load; cpu_reset falls 11 edges after the start edge
        b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        push_prog(b);
        do_start(2);
        chk("load_busy", 64'(busy), 64'(1));
        stream(b, 1'b0);
        wait_run();
        chk("rst_fall_lat", 64'(cyc - start_cyc), 64'(11));
        chk("two_word_q_empty", 64'(exp_q.size()), 64'(0));
        run_then_halt(6);

        // Restart from DONE with a gapped loader
        push_prog(b);
        do_start(2);
        chk("restart_done_clr", 64'(done), 64'(0));
        chk("restart_runcyc_clr", 64'(run_cycles), 64'(0));
        chk("restart_cpu_reset", 64'(cpu_reset), 64'(1));
        stream(b, 1'b1);
        wait_run();
        chk("gapped_q_empty", 64'(exp_q.size()), 64'(0));
        run_then_halt(3);

        // Pause then halt with a 3-word random program
        b.delete();
        for (int i = 0; i < 12; i++) b.push_back(8'($urandom_range(0, 255)));
        push_prog(b);
        do_start(3);
        stream(b, 1'b0);
        wait_run();
        repeat (3) tick();                       // RUN cycle 4
        chk("pre_pause_th", 64'(cpu_test_halt), 64'(0));
        pause_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("pause_th", 64'(cpu_test_halt), 64'(1));
            if (i == 2) chk("pause_runcyc_frozen", 64'(run_cycles), 64'(4));
        end
        pause_req = 1'b0;
        tick();                                  // RUN cycle 5
        chk("unpause_th", 64'(cpu_test_halt), 64'(0));
        repeat (2) tick();                       // RUN cycle 7
        cpu_halted = 1'b1;
        tick();
        cpu_halted = 1'b0;
        chk("pause_done", 64'(done), 64'(1));
        chk("pause_runcyc", 64'(run_cycles), 64'(7));
        chk("pause_done_th", 64'(cpu_test_halt), 64'(0));

        // Watchdog with zero-length program
        do_start(0);
        wait_run();
        chk("len0_rst_fall_lat", 64'(cyc - start_cyc), 64'(1));
        repeat (MAXC - 1) tick();
        chk("wd_not_yet", 64'(timeout), 64'(0));
        tick();
        chk("wd_timeout", 64'(timeout), 64'(1));
        chk("wd_th", 64'(cpu_test_halt), 64'(1));
        chk("wd_runcyc", 64'(run_cycles), 64'(MAXC));
        chk("wd_done", 64'(done), 64'(0));
        chk("wd_busy", 64'(busy), 64'(0));

        // Halt and pause together: halt wins
        do_start(0);
        chk("restart_to_clr", 64'(timeout), 64'(0));
        wait_run();
        tick();
        cpu_halted = 1'b1;
        pause_req  = 1'b1;
        tick();
        cpu_halted = 1'b0;
        pause_req  = 1'b0;
        chk("sim_hp_done", 64'(done), 64'(1));
        chk("sim_hp_timeout", 64'(timeout), 64'(0));
        chk("sim_hp_th", 64'(cpu_test_halt), 64'(0));
        chk("sim_hp_runcyc", 64'(run_cycles), 64'(2));

        // Halt on the watchdog cycle: halt wins
        do_start(0);
        wait_run();
        repeat (MAXC - 1) tick();
        cpu_halted = 1'b1;
        tick();
        cpu_halted = 1'b0;
        chk("sim_hw_done", 64'(done), 64'(1));
        chk("sim_hw_timeout", 64'(timeout), 64'(0));
        chk("sim_hw_runcyc", 64'(run_cycles), 64'(MAXC));

        // Reset mid-load after 2 bytes, then a full reload
        b = '{8'hDE, 8'hAD};
        do_start(1);
        stream(b, 1'b0);
        reset = 1'b1;
        tick();
        chk_reset_vals("midload_rst");
        reset = 1'b0;
        tick();
        b = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        push_prog(b);
        do_start(1);
        stream(b, 1'b0);
        wait_run();
        run_then_halt(2);

        repeat (3) tick();
        chk("final_q_empty", 64'(exp_q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
